// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, bubble word, reset PC.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INS_DEF  = 32'd0;
    localparam logic [29:0] RESET_PC_DEF = 30'h0000_0C00;

    // Word-address increment; wraps modulo 2^30.
    function automatic logic [29:0] word_inc(input logic [29:0] a);
        return a + 30'd1;
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Purpose: redirect target priority mux (branch > jr > jump) and sequential PC+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is loaded.
module if_next_pc
    import if_fetch_stage_pkg::*;
(
    input  logic [29:0] pc,
    input  logic        br_taken,
    input  logic [29:0] br_target,
    input  logic        jr,
    input  logic [29:0] jr_target,
    input  logic [29:0] jmp_target,
    output logic [29:0] target,
    output logic [29:0] pc_plus1
);

    always_comb begin
        target = jmp_target;
        if (br_taken)
            target = br_target;
        else if (jr)
            target = jr_target;
    end

    assign pc_plus1 = word_inc(pc);

endmodule

// File: rtl/if_fetch_stage.sv
// Purpose: IF stage - owns the PC, picks the next PC, runs a single-outstanding imem handshake.
// Latency: one cycle per word at imem_ready=1; every imem wait cycle inserts one NOP bubble.
// Backpressure: hazard holds the PC and masks redirects; IF_PERF_CNT_EN adds fetch/stall counters.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [29:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INS  = NOP_INS_DEF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        hazard,
    input  logic        br_taken,
    input  logic [29:0] br_target,
    input  logic        jmp,
    input  logic [29:0] jmp_target,
    input  logic        jr,
    input  logic [29:0] jr_target,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_ins,
    output logic [29:0] PC_plus_4,
    output logic        if_flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    if_state_t   state;
    logic [29:0] pc;
    logic [29:0] pend_target;
    logic [29:0] target;
    logic [29:0] pc_inc;
    logic        redirect;

    if_next_pc u_next_pc (
        .pc         (pc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jr         (jr),
        .jr_target  (jr_target),
        .jmp_target (jmp_target),
        .target     (target),
        .pc_plus1   (pc_inc)
    );

    assign redirect  = !hazard && (br_taken || jr || jmp);
    assign imem_req  = (state != S_BOOT);
    assign imem_addr = pc;
    assign if_flush  = (state != S_BOOT) && redirect;
    assign if_ins    = (state == S_FETCH && imem_ready) ? imem_rdata : NOP_INS;
    assign PC_plus_4 = pc_inc;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            pend_target <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_FETCH;
                S_FETCH: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc <= target;
                        end else begin
                            // Request already on the bus must complete before the new PC can go out.
                            pend_target <= target;
                            state       <= S_DRAIN;
                        end
                    end else if (imem_ready && !hazard) begin
                        pc <= pc_inc;
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc    <= target;
                            state <= S_FETCH;
                        end else begin
                            pend_target <= target;
                        end
                    end else if (imem_ready) begin
                        pc    <= pend_target;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == S_FETCH && imem_ready && !hazard && !redirect)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (hazard || (imem_req && !imem_ready))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: per-cycle expectations queued by the stimulus, checked by a monitor.
module tb_if_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        hazard = 1'b0;
    logic        br_taken = 1'b0;
    logic [29:0] br_target = '0;
    logic        jmp = 1'b0;
    logic [29:0] jmp_target = '0;
    logic        jr = 1'b0;
    logic [29:0] jr_target = '0;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_ins;
    logic [29:0] PC_plus_4;
    logic        if_flush;

    if_fetch_stage dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .hazard     (hazard),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .jr         (jr),
        .jr_target  (jr_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_ins     (if_ins),
        .PC_plus_4  (PC_plus_4),
        .if_flush   (if_flush)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        req;
        logic [29:0] addr;
        logic [31:0] ins;
        logic        chk_ins;
        logic        flush;
        logic [29:0] p4;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: where the next fetch goes, plus an optional redirect still waiting on a stale request.
    bit          m_boot;
    bit          m_stale;
    logic [29:0] m_pc;
    logic [29:0] m_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_stale = 1'b0;
        m_pc    = 30'h0000_0C00;
        m_pend  = '0;
    endtask

    task automatic cyc(input bit hz, input bit br, input logic [29:0] bt, input bit j_r,
                       input logic [29:0] jt, input bit jm, input logic [29:0] mt, input bit rdy);
        exp_t        e;
        bit          redir;
        logic [29:0] tgt;
        hazard     = hz;
        br_taken   = br;
        br_target  = bt;
        jr         = j_r;
        jr_target  = jt;
        jmp        = jm;
        jmp_target = mt;
        imem_ready = rdy;
        imem_rdata = $urandom;
        redir = !hz && (br || j_r || jm);
        tgt   = br ? bt : (j_r ? jt : mt);
        e.req   = !m_boot;
        e.addr  = m_pc;
        e.p4    = m_pc + 30'd1;
        e.flush = !m_boot && redir;
        if (m_boot || m_stale) begin
            e.ins     = 32'd0;
            e.chk_ins = 1'b1;
        end else begin
            e.ins     = rdy ? imem_rdata : 32'd0;
            e.chk_ins = !redir;
        end
        exp_q.push_back(e);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (redir) begin
            if (rdy) begin
                m_pc    = tgt;
                m_stale = 1'b0;
            end else begin
                m_pend  = tgt;
                m_stale = 1'b1;
            end
        end else if (m_stale) begin
            if (rdy) begin
                m_pc    = m_pend;
                m_stale = 1'b0;
            end
        end else if (rdy && !hz) begin
            m_pc = m_pc + 30'd1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic seq(input bit rdy);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
            if (e.req)
                chk("imem_addr", {2'd0, imem_addr}, {2'd0, e.addr});
            chk("if_flush", {31'd0, if_flush}, {31'd0, e.flush});
            chk("PC_plus_4", {2'd0, PC_plus_4}, {2'd0, e.p4});
            if (e.chk_ins)
                chk("if_ins", if_ins, e.ins);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_if_ins"}, if_ins, 32'd0);
        chk({tag, "_if_flush"}, {31'd0, if_flush}, 32'd0);
        chk({tag, "_PC_plus_4"}, {2'd0, PC_plus_4}, 32'h0000_0C01);
        chk({tag, "_imem_addr"}, {2'd0, imem_addr}, 32'h0000_0C00);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10, 30'($urandom),
                $urandom_range(0, 99) < 6, 30'($urandom), $urandom_range(0, 99) < 6,
                30'($urandom), $urandom_range(0, 99) < 70);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_outputs("reset");
        #6;
        Rst_n = 1'b1;

        // Boot bubble then straight-line fetch from 0xC00.
        for (int i = 0; i < 5; i++) seq(1'b1);
        // Memory wait at 0xC04.
        for (int i = 0; i < 3; i++) seq(1'b0);
        seq(1'b1);
        // Load-use hazard at 0xC05 with a branch that must be ignored.
        cyc(1'b1, 1'b1, 30'h123, 1'b0, '0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b1, 30'h123, 1'b0, '0, 1'b0, '0, 1'b1);
        seq(1'b1);
        // Taken branch to 0xD00 with ready data.
        cyc(1'b0, 1'b1, 30'hD00, 1'b0, '0, 1'b0, '0, 1'b1);
        seq(1'b1);
        // jr to 0xE00 while memory is busy: stale request drains first.
        cyc(1'b0, 1'b0, '0, 1'b1, 30'hE00, 1'b0, '0, 1'b0);
        seq(1'b0);
        seq(1'b1);
        seq(1'b1);
        // Jump to the top of the address space, then wrap to 0.
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 30'h3FFF_FFFF, 1'b1);
        seq(1'b1);
        seq(1'b1);
        // Priority when all three redirects fire together.
        cyc(1'b0, 1'b1, 30'h0AA, 1'b1, 30'h0BB, 1'b1, 30'h0CC, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 30'h0BB, 1'b1, 30'h0CC, 1'b1);
        seq(1'b1);

        random_cycles(3000);

        // Reset asserted while a fetch is waiting on memory.
        seq(1'b0);
        imem_ready = 1'b0;
        Rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        Rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) seq(1'b1);
        random_cycles(1000);

        @(negedge Clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
